// File: rtl/pipelined_look_ahead_carry_adder.sv
// pipelined_look_ahead_carry_adder
//   Pipelined add/subtract unit built from 4-bit look-ahead carry groups.
//   Each stage resolves one 4-bit group and registers its carry into the next
//   stage. Latency is NUM_STAGES = DATA_WIDTH/4 cycles. Throughput is one beat
//   per cycle. A single global stall freezes every stage.
//
// Parameters
//   DATA_WIDTH    operand/sum width; multiple of 4, minimum 4
//
// Ports
//   Clock_In      rising-edge clock
//   Reset_n_In    synchronous active-low reset
//   Data_A_In     operand A
//   Data_B_In     operand B
//   Carry_In      carry into bit 0 (ignored when subtracting)
//   Sub_In        0: A+B+Carry_In, 1: A-B
//   Valid_In      input beat valid
//   Ready_Out     unit can accept a beat this cycle
//   Sum_Out       result (modulo 2^DATA_WIDTH)
//   Carry_Out     carry out of MSB (subtract: 1 = no borrow)
//   Valid_Out     Sum_Out/Carry_Out valid
//   Ready_In      downstream accepts result
//   Overflow_Out  signed overflow flag, only present with LACA_OVERFLOW_FLAG_EN
//
// Optional feature macro: LACA_OVERFLOW_FLAG_EN
module pipelined_look_ahead_carry_adder #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    input  logic                  Sub_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In
`ifdef LACA_OVERFLOW_FLAG_EN
    ,
    output logic                  Overflow_Out
`endif
);

    localparam int unsigned NUM_STAGES = DATA_WIDTH / 4;

    // 4-bit look-ahead group: returns {carry into bit 3, carry out, sum[3:0]}.
    function automatic logic [5:0] lac4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c3, c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Per-stage registers; a/b carry the not-yet-resolved upper groups.
    logic [NUM_STAGES-1:0] valid_q;
    logic [DATA_WIDTH-1:0] a_q     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_q     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] sum_q   [NUM_STAGES];
    logic                  carry_q [NUM_STAGES];

    // Stage inputs and next-state values
    logic [NUM_STAGES-1:0] stg_v;
    logic [DATA_WIDTH-1:0] stg_a   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] stg_b   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] stg_s   [NUM_STAGES];
    logic                  stg_c   [NUM_STAGES];
    logic [5:0]            grp     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] sum_d   [NUM_STAGES];

    logic stall;

    assign Valid_Out = valid_q[NUM_STAGES-1];
    assign Sum_Out   = sum_q[NUM_STAGES-1];
    assign Carry_Out = carry_q[NUM_STAGES-1];
    assign stall     = Valid_Out & ~Ready_In;
    assign Ready_Out = ~stall;

    always_comb begin
        // Stage 0 takes the live operands; subtraction is A + ~B + 1.
        stg_v[0] = Valid_In;
        stg_a[0] = Data_A_In;
        stg_b[0] = Sub_In ? ~Data_B_In : Data_B_In;
        stg_c[0] = Sub_In ? 1'b1 : Carry_In;
        stg_s[0] = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stg_v[k] = valid_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
            stg_c[k] = carry_q[k-1];
            stg_s[k] = sum_q[k-1];
        end
        for (int k = 0; k < NUM_STAGES; k++) begin
            grp[k]   = lac4(stg_a[k][4*k +: 4], stg_b[k][4*k +: 4], stg_c[k]);
            sum_d[k] = stg_s[k];
            sum_d[k][4*k +: 4] = grp[k][3:0];
        end
    end

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q <= stg_v;
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]     <= stg_a[k];
                b_q[k]     <= stg_b[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= grp[k][4];
            end
        end
    end

`ifdef LACA_OVERFLOW_FLAG_EN
    // MSB lives in the last group, so overflow is resolved in the last stage.
    logic ovf_q;

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= grp[NUM_STAGES-1][5] ^ grp[NUM_STAGES-1][4];
        end
    end

    assign Overflow_Out = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_look_ahead_carry_adder.sv
// Testbench for pipelined_look_ahead_carry_adder (DATA_WIDTH=16).
// Directed vectors with literal expectations plus a scoreboard that checks
// every valid output against an arithmetic model.
module tb_pipelined_look_ahead_carry_adder;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          cin, sub, vin, rdy_in;
    logic          rdy_out, cout, vout;
    logic [W-1:0]  sum;
`ifdef LACA_OVERFLOW_FLAG_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    pipelined_look_ahead_carry_adder #(.DATA_WIDTH(W)) dut (
        .Clock_In   (clk),
        .Reset_n_In (rst_n),
        .Data_A_In  (a),
        .Data_B_In  (b),
        .Carry_In   (cin),
        .Sub_In     (sub),
        .Valid_In   (vin),
        .Ready_Out  (rdy_out),
        .Sum_Out    (sum),
        .Carry_Out  (cout),
        .Valid_Out  (vout),
        .Ready_In   (rdy_in)
`ifdef LACA_OVERFLOW_FLAG_EN
        ,
        .Overflow_Out (ovf)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {overflow, carry_out, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         o;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + ((msub | mcin) ? (W+1)'(1) : (W+1)'(0));
        o  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
        return {o, r[W], r[W-1:0]};
    endfunction

    // Scoreboard / compare process
    logic [W+1:0] exp_q[$];
    logic         rst_prev = 1'b0;
    logic         started  = 1'b0;

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_prev) begin
            chk("rst_valid", vout, 0);
            chk("rst_sum", sum, 0);
            chk("rst_cout", cout, 0);
            chk("rst_ready", rdy_out, 1);
        end
        if (started) chk("ready_rule", rdy_out, !(vout && !rdy_in));
        if (vout === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", vout, 0);
            end else begin
                e = exp_q[0];
                chk("sb_sum", sum, e[W-1:0]);
                chk("sb_cout", cout, e[W]);
`ifdef LACA_OVERFLOW_FLAG_EN
                chk("sb_ovf", ovf, e[W+1]);
`endif
                if (rdy_in) void'(exp_q.pop_front());
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            started = 1'b1;
        end else if (vin && rdy_out) begin
            exp_q.push_back(model(a, b, cin, sub));
        end
        rst_prev = !rst_n;
    end

    // Single beat into an idle pipe; checks literal result and latency.
    task automatic send_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tcin, input logic tsub, input logic [W-1:0] es,
                              input logic ec, input logic eo);
        int n;
        chk({name, "_model"}, model(ta, tb, tcin, tsub), {eo, ec, es});
        a = ta; b = tb; cin = tcin; sub = tsub; vin = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            vin = 1'b0;
            n++;
        end while (!vout && n < 20);
        chk({name, "_latency"}, n, NS);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, cout, ec);
`ifdef LACA_OVERFLOW_FLAG_EN
        chk({name, "_ovf"}, ovf, eo);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int n, first, idx;
        logic acc;
        logic [W-1:0] held;

        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; vin = 1'b0; rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single beats
        send_check("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_check("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_check("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_check("sub_cin0", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_check("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_check("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // Back-to-back streaming
        n = 0; first = -1;
        for (int c = 0; c < 16; c++) begin
            vin = (c < 8); a = 16'(c); b = 16'h00FF; cin = 1'b1; sub = 1'b0;
            @(posedge clk); #1;
            if (vout) begin
                if (n == 0) first = c;
                chk("stream_sum", sum, 16'h0100 + 16'(n));
                n++;
            end
        end
        vin = 1'b0;
        chk("stream_count", n, 8);
        chk("stream_first", first, NS - 1);

        // Backpressure: Ready_In low for 3 cycles while a result is valid
        idx = 0; held = '0;
        for (int c = 0; c < 30; c++) begin
            rdy_in = !(c >= 5 && c < 8);
            vin = (idx < 6); a = 16'h0010 + 16'(idx); b = 16'h0F00; cin = 1'b0; sub = 1'b0;
            #1;
            acc = vin && rdy_out;
            if (c == 5) held = sum;
            if (c >= 5 && c < 8) begin
                chk("bp_valid", vout, 1);
                chk("bp_ready", rdy_out, 0);
                chk("bp_hold", sum, held);
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        vin = 1'b0; rdy_in = 1'b1;
        chk("bp_sent", idx, 6);
        chk("bp_drain", exp_q.size(), 0);

        // Reset mid-operation
        for (int c = 0; c < 3; c++) begin
            vin = 1'b1; a = 16'h0100 + 16'(c); b = 16'h0001; cin = 1'b0; sub = 1'b0;
            if (c == 2) rst_n = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1; vin = 1'b0;
        chk("mid_rst_valid", vout, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_ready", rdy_out, 1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("no_stale", vout, 0);
        end
        send_check("post_rst", 16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_look_ahead_carry_adder.md
Name: pipelined_look_ahead_carry_adder

Overview:
Parametrised, pipelined add/subtract unit built from 4-bit look-ahead carry groups.
- Operand width is DATA_WIDTH, split into DATA_WIDTH/4 groups.
- Each pipeline stage resolves one group with full 4-bit look-ahead logic (P/G per bit, carries in parallel) and registers the group carry into the next stage.
- Sits in the arithmetic library as the high-width, high-Fmax adder for datapaths using valid/ready streaming.

Parameters:
DATA_WIDTH, 16, operand/sum width in bits; multiple of 4, minimum 4.
NUM_STAGES, DATA_WIDTH/4, derived localparam (not overridable); pipeline depth and latency in cycles.

Ports:
Clock_In  input  1  clock; all state updates on rising edge.
Reset_n_In  input  1  synchronous, active-low reset.
Data_A_In  input  DATA_WIDTH  operand A.
Data_B_In  input  DATA_WIDTH  operand B.
Carry_In  input  1  carry into bit 0; ignored when Sub_In=1.
Sub_In  input  1  0: A+B+Carry_In; 1: A+~B+1 (A-B).
Valid_In  input  1  input beat valid.
Ready_Out  output  1  unit can accept a beat this cycle.
Sum_Out  output  DATA_WIDTH  result.
Carry_Out  output  1  carry out of MSB (for subtract: 1 = no borrow).
Valid_Out  output  1  Sum_Out/Carry_Out valid.
Ready_In  input  1  downstream accepts result.

Behaviour:
- Reset (Reset_n_In=0 at a clock edge) clears all stage valid bits, data and carry registers.
  - Outputs during and after reset: Valid_Out=0, Sum_Out=0, Carry_Out=0.
  - Ready_Out=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Stall rule (global): stall = Valid_Out & ~Ready_In.
  - Ready_Out = ~stall (combinational).
  - On stall every pipeline register holds its value.
  - Bubbles are not collapsed.
- Accept: an input beat is captured when Valid_In & Ready_Out.
  - If Valid_In=0 and not stalled, a bubble (valid=0) enters stage 0.
- Stage 0 captures:
  - B_eff = Sub_In ? ~Data_B_In : Data_B_In.
  - c0 = Sub_In ? 1 : Carry_In.
  - Group 0 sum computed with look-ahead logic.
  - The group 0 carry-out is registered.
  - The remaining operand groups are registered unmodified (skew buffer).
- Stage k (1..NUM_STAGES-1):
  - Takes the registered carry from stage k-1.
  - Computes group k sum and carry with look-ahead equations: c_i+1 = G_i | (P_i & c_i), flattened; P = a^b, G = a&b, s_i = P_i ^ c_i.
  - Passes the already-computed lower sum groups along.
- Latency: exactly NUM_STAGES cycles from acceptance to Valid_Out=1 when no stall occurs.
- Throughput: one beat per cycle.
- Output registers are the last stage registers; Sum_Out and Carry_Out hold steady while Valid_Out=1 & Ready_In=0.
- Ordering: results emerge strictly in acceptance order, one result per accepted beat.
- Simultaneous events:
  - Accept and output handshake in the same cycle both occur; the pipeline advances one step.
  - Valid_In asserted while stalled is not captured; the source must hold it.
- Wrap-around: the sum is modulo 2^DATA_WIDTH; overflow is reported only via Carry_Out (and the optional flag).
- DATA_WIDTH=4 degenerates to a single registered 4-bit look-ahead adder (latency 1).

Optional Feature:
Macro LACA_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port Overflow_Out (1 bit), asserted with Valid_Out.
  - Value is signed two's-complement overflow = carry into MSB XOR carry out of MSB, pipelined alongside the result.
  - Reset value 0; held during stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. DATA_WIDTH=16, A=0xFFFF, B=0x0001, Carry_In=0, Sub_In=0, Ready_In=1 -> after 4 cycles Valid_Out=1, Sum_Out=0x0000, Carry_Out=1 (Overflow_Out=0 if enabled).
2. Sub: A=0x0005, B=0x0007, Sub_In=1, Carry_In=1 -> Sum_Out=0xFFFE, Carry_Out=0. Then A=0x0007, B=0x0005 -> Sum_Out=0x0002, Carry_Out=1.
3. Overflow: A=0x7FFF, B=0x0001, Carry_In=0 -> Sum_Out=0x8000, Carry_Out=0, Overflow_Out=1 (macro defined); port absent when undefined.
4. Streaming: 8 back-to-back beats A=i, B=0x00FF, Carry_In=1, i=0..7, Ready_In=1 -> Valid_Out high 8 consecutive cycles starting cycle 4, Sum_Out=0x0100+i, in order.
5. Backpressure: stream beats; drop Ready_In for 3 cycles while Valid_Out=1 -> Ready_Out=0 those cycles, Sum_Out constant, no beat lost or duplicated, order preserved after release.
6. Reset: accept 3 beats, assert Reset_n_In=0 one cycle at cycle 2 -> next cycle Valid_Out=0, Sum_Out=0, Ready_Out=1; no stale result ever appears; new beat afterwards returns after exactly 4 cycles.
